// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish at once.
module seq_divider #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [1:0]   op,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int CntW = $clog2(n);
  localparam logic [n-1:0] MinVal = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [n-1:0]      quo_q, rem_q, div_q, result_q;
  logic              remSel_q, qneg_q, rneg_q, done_q;

  logic [n:0]        shifted, diff;
  logic [n-1:0]      stepQuo_d, stepRem_d, fixQuo_d, fixRem_d, finalRes_d;
  logic [n-1:0]      absA, absB;
  logic              isSigned, divZero, overflow;

  // quo_q doubles as the dividend shift register: its MSB feeds the remainder
  // while fresh quotient bits enter at the LSB.
  always_comb begin
    shifted    = {rem_q, quo_q[n-1]};
    diff       = shifted - {1'b0, div_q};
    stepRem_d  = diff[n] ? shifted[n-1:0] : diff[n-1:0];
    stepQuo_d  = {quo_q[n-2:0], ~diff[n]};
    fixQuo_d   = qneg_q ? -stepQuo_d : stepQuo_d;
    fixRem_d   = rneg_q ? -stepRem_d : stepRem_d;
    finalRes_d = remSel_q ? fixRem_d : fixQuo_d;
    isSigned   = ~op[0];
    absA       = (isSigned && A[n-1]) ? -A : A;
    absB       = (isSigned && B[n-1]) ? -B : B;
    divZero    = (B == '0);
    overflow   = isSigned && (A == MinVal) && (B == '1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      result_q <= '0;
      remSel_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !flush) begin
            remSel_q <= op[1];
            cnt_q    <= '0;
            if (divZero) begin
              quo_q    <= '1;
              rem_q    <= A;
              qneg_q   <= 1'b0;
              rneg_q   <= 1'b0;
              result_q <= op[1] ? A : '1;
              done_q   <= 1'b1;
              state_q  <= FINISH;
            end else if (overflow) begin
              quo_q    <= A;
              rem_q    <= '0;
              qneg_q   <= 1'b0;
              rneg_q   <= 1'b0;
              result_q <= op[1] ? '0 : A;
              done_q   <= 1'b1;
              state_q  <= FINISH;
            end else begin
              quo_q    <= absA;
              div_q    <= absB;
              rem_q    <= '0;
              qneg_q   <= isSigned & (A[n-1] ^ B[n-1]);
              rneg_q   <= isSigned & A[n-1];
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            quo_q <= stepQuo_d;
            rem_q <= stepRem_d;
            cnt_q <= cnt_q + 1'b1;
            // The final step's sign-fixed result is loaded while entering
            // FINISH, so done and result become visible together.
            if (cnt_q == CntW'(n-1)) begin
              result_q <= finalRes_d;
              done_q   <= 1'b1;
              state_q  <= FINISH;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);

endmodule
